// File: rtl/rv32i_pkg.sv
// Shared fetch-stage types: FSM encoding, buffered entry layout and the NOP
// that stands in for a misaligned fetch.
package rv32i_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        misalign;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Decode-side instruction buffer. Flush clears it on the same edge and wins
// over a concurrent push or pop. A full buffer accepts a push only alongside a pop.
module ifetch_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         empty,
  output logic         full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  // Zero the head when empty so decode sees clean fields out of reset.
  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: one outstanding memory read at a time, misaligned PCs
// become NOP entries, and flush cancels buffered and in-flight work.
module ifetch
  import rv32i_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        id_misalign
);

  fetch_state_t state;
  fetch_state_t state_nxt;
  fetch_entry_t push_data;
  fetch_entry_t head;
  logic         push;
  logic         accept;
  logic         aligned;
  logic         empty;
  logic         full;

  assign aligned     = (fetch_pc[1:0] == 2'b00);
  assign fetch_ready = (state == IDLE) && !flush && !full;
  assign accept      = fetch_valid && fetch_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && aligned) state_nxt = WAIT;
      WAIT: begin
        if (flush)            state_nxt = imem_rvalid ? IDLE : DROP;
        else if (imem_rvalid) state_nxt = IDLE;
      end
      // The cancelled read still has to come back before a new one may go out.
      DROP: if (imem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    push               = 1'b0;
    push_data.instr    = NOP_INSTR;
    push_data.pc       = fetch_pc;
    push_data.misalign = 1'b1;
    if (state == WAIT && imem_rvalid && !flush) begin
      push               = 1'b1;
      push_data.instr    = imem_rdata;
      push_data.pc       = imem_addr;
      push_data.misalign = 1'b0;
    end else if (accept && !aligned) begin
      push = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      state    <= state_nxt;
      imem_req <= accept && aligned;
      if (accept && aligned) imem_addr <= fetch_pc;
    end
  end

  ifetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (push),
    .push_data(push_data),
    .pop      (id_ready),
    .head     (head),
    .empty    (empty),
    .full     (full)
  );

  assign id_valid    = !empty;
  assign id_instr    = head.instr;
  assign id_pc       = head.pc;
  assign id_misalign = head.misalign;

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios then random traffic,
// all compared against a transaction-level model of the fetch stage.
module tb_ifetch;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_misalign;

  always #5 clk = ~clk;

  ifetch #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready), .flush(flush), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_misalign(id_misalign)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        mis;
  } ent_t;

  int tests = 0;
  int fails = 0;

  // Model: instructions expected at decode, plus the one read that may be in flight.
  ent_t        q[$];
  bit          m_out = 1'b0;
  bit          m_cancel = 1'b0;
  bit          exp_req = 1'b0;
  logic [31:0] m_addr = '0;

  // Memory environment.
  int          cyc = 0;
  bit          mem_pend = 1'b0;
  int          mem_due = 0;
  logic [31:0] mem_a = '0;
  int          mem_delay = 1;

  bit          last_acc;
  int          dut_pops = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    if (a == 32'h100) return 32'h00500093;
    return (a * 32'h00010001) ^ 32'h00000033;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check registered outputs, drive inputs, check fetch_ready,
  // then advance the model across the coming edge.
  task automatic tick(input bit fv, input logic [31:0] pc, input bit fl,
                      input bit rdy, input bit rs, input bit xrv);
    bit rv;
    bit pred;
    bit acc;
    @(negedge clk);
    check("id_valid", 32'(id_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("id_instr", id_instr, q[0].instr);
      check("id_pc", id_pc, q[0].pc);
      check("id_misalign", 32'(id_misalign), 32'(q[0].mis));
    end
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req || m_out) check("imem_addr", imem_addr, m_addr);
    if (id_valid && rdy) dut_pops++;

    if (imem_req) begin
      mem_pend = 1'b1;
      mem_due  = cyc + mem_delay;
      mem_a    = imem_addr;
    end
    rv = mem_pend && (mem_due == cyc);
    if (rv) mem_pend = 1'b0;

    rst         = rs;
    flush       = fl;
    fetch_valid = fv;
    fetch_pc    = pc;
    id_ready    = rdy;
    imem_rvalid = rv || xrv;
    imem_rdata  = rv ? instr_of(mem_a) : 32'hDEADBEEF;
    #1;
    pred = !m_out && !fl && (q.size() < DEPTH);
    check("fetch_ready", 32'(fetch_ready), 32'(pred));
    acc      = fv && pred && !rs;
    last_acc = acc;

    exp_req = 1'b0;
    if (rs) begin
      q.delete();
      m_out    = 1'b0;
      m_cancel = 1'b0;
      m_addr   = '0;
    end else if (fl) begin
      q.delete();
      if (m_out) begin
        if (imem_rvalid) begin
          m_out    = 1'b0;
          m_cancel = 1'b0;
        end else begin
          m_cancel = 1'b1;
        end
      end
    end else begin
      if (rdy && q.size() != 0) void'(q.pop_front());
      if (m_out && imem_rvalid) begin
        if (!m_cancel) q.push_back('{instr_of(m_addr), m_addr, 1'b0});
        m_out    = 1'b0;
        m_cancel = 1'b0;
      end
      if (acc) begin
        if (pc[1:0] == 2'b00) begin
          m_out   = 1'b1;
          m_addr  = pc;
          exp_req = 1'b1;
        end else begin
          q.push_back('{32'h00000013, pc, 1'b1});
        end
      end
    end
    cyc++;
  endtask

  initial begin
    logic [31:0] nxt;
    logic [31:0] rpc;
    int          pops0;

    rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_pc = '0;
    id_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    repeat (2) @(posedge clk);

    // Reset state
    tick(0, 0, 0, 0, 1, 0);
    check("rst_id_instr", id_instr, 32'h0);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_id_misalign", 32'(id_misalign), 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_imem_req", 32'(imem_req), 32'h0);
    tick(0, 0, 0, 0, 0, 0);

    // Stray response while idle
    tick(0, 0, 0, 1, 0, 1);
    tick(0, 0, 0, 1, 0, 0);
    check("idle_rvalid_ignored", 32'(id_valid), 32'h0);

    // Basic aligned fetch with exact latency
    mem_delay = 1;
    tick(1, 32'h100, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    check("lat_req", 32'(imem_req), 32'h1);
    check("lat_addr", imem_addr, 32'h100);
    tick(0, 0, 0, 0, 0, 0);
    check("lat_not_yet", 32'(id_valid), 32'h0);
    tick(0, 0, 0, 0, 0, 0);
    check("lat_valid", 32'(id_valid), 32'h1);
    check("lat_instr", id_instr, 32'h00500093);
    check("lat_pc", id_pc, 32'h100);
    tick(0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 1, 0, 0);

    // Misaligned fetch becomes a NOP entry without a memory request
    tick(1, 32'h102, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    check("mis_no_req", 32'(imem_req), 32'h0);
    check("mis_valid", 32'(id_valid), 32'h1);
    check("mis_instr", id_instr, 32'h00000013);
    check("mis_flag", 32'(id_misalign), 32'h1);
    check("mis_pc", id_pc, 32'h102);
    tick(0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 1, 0, 0);

    // Back-pressure: buffer fills, third fetch waits for a pop
    nxt = 32'h0;
    for (int i = 0; i < 12; i++) begin
      tick(1, nxt, 0, 0, 0, 0);
      if (last_acc) nxt += 4;
    end
    check("bp_ready_low", 32'(fetch_ready), 32'h0);
    check("bp_two_taken", nxt, 32'h8);
    check("bp_head", id_pc, 32'h0);
    for (int i = 0; i < 12; i++) begin
      tick(nxt <= 32'h8, nxt, 0, 1, 0, 0);
      if (last_acc) nxt += 4;
    end
    check("bp_third_taken", nxt, 32'hC);

    // Flush while waiting; late response must never reach decode
    mem_delay = 2;
    tick(1, 32'h10, 0, 1, 0, 0);
    tick(0, 0, 1, 1, 0, 0);
    mem_delay = 1;
    for (int i = 0; i < 8; i++) begin
      tick(1, 32'h40, 0, 0, 0, 0);
      if (last_acc) break;
    end
    check("fl_accepted", 32'(last_acc), 32'h1);
    repeat (3) tick(0, 0, 0, 0, 0, 0);
    check("fl_valid", 32'(id_valid), 32'h1);
    check("fl_first_pc", id_pc, 32'h40);
    tick(0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 1, 0, 0);

    // Reset while waiting with one buffered entry; response after reset ignored
    tick(1, 32'h20, 0, 0, 0, 0);
    repeat (3) tick(0, 0, 0, 0, 0, 0);
    check("rw_buffered", 32'(id_valid), 32'h1);
    mem_delay = 2;
    tick(1, 32'h24, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    check("rw_id_valid", 32'(id_valid), 32'h0);
    check("rw_idle", 32'(fetch_ready), 32'h1);
    mem_delay = 1;
    repeat (3) tick(0, 0, 0, 1, 0, 0);

    // Streaming throughput: one instruction every three cycles
    nxt   = 32'h200;
    pops0 = dut_pops;
    for (int i = 0; i < 30; i++) begin
      tick(1, nxt, 0, 1, 0, 0);
      if (last_acc) nxt += 4;
    end
    check("stream_pops", 32'(dut_pops - pops0), 32'd9);
    repeat (4) tick(0, 0, 0, 1, 0, 0);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      mem_delay = $urandom_range(1, 3);
      rpc = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 99) < 15) rpc = rpc + 32'($urandom_range(1, 3));
      tick($urandom_range(0, 99) < 70, rpc, $urandom_range(0, 99) < 6,
           $urandom_range(0, 99) < 60, 0, 0);
    end
    repeat (8) tick(0, 0, 0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
